// File: rtl/alpha_collector.sv
// alpha_collector: collects alpha bursts from the last PE into a
// first-word-fall-through FIFO.  Each stored word carries a "last" tag
// marking the final word of a burst.  A write-side FSM tracks the burst
// word index and an idle-gap timeout.  Sticky flags report dropped words
// (overflow) and aborted bursts (burst_err).
// Optional feature: define ALPHA_COLLECTOR_SCALE_EN to halve (rounding)
// each 16-bit component of din before storage.
module alpha_collector #(
  parameter int DEPTH     = 16,
  parameter int BURST_LEN = 8,
  parameter int GAP_MAX   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     din_v,
  input  logic [31:0]              din,
  input  logic                     dout_ready,
  input  logic                     clr_err,
  output logic                     dout_valid,
  output logic [31:0]              dout,
  output logic                     dout_last,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     burst_err,
  output logic [7:0]               frame_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int WW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int GW = (GAP_MAX > 1) ? $clog2(GAP_MAX) : 1;
  localparam logic [WW-1:0] WLAST = WW'(BURST_LEN - 1);
  localparam logic [GW-1:0] GLAST = GW'(GAP_MAX - 1);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  // Storage: bit 32 is the last-of-burst tag, bits 31:0 the alpha word.
  logic [32:0]    mem_q [DEPTH];

  logic [AW-1:0]  wptr_q, wptr_d;
  logic [AW-1:0]  rptr_q, rptr_d;
  logic [LW-1:0]  level_q, level_d;
  logic           dout_valid_q, dout_valid_d;
  logic [31:0]    dout_q, dout_d;
  logic           dout_last_q, dout_last_d;

  state_t         state_q, state_d;
  logic [WW-1:0]  widx_q, widx_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic [7:0]     frame_q, frame_d;
  logic           overflow_q, overflow_d;
  logic           burst_err_q, burst_err_d;

  logic           full_s;
  logic           wr_en_s;
  logic           rd_en_s;
  logic           last_tag_s;
  logic           timeout_s;
  logic           ovf_set_s;
  logic [31:0]    wdata_s;

`ifdef ALPHA_COLLECTOR_SCALE_EN
  // Rounded halving: (x + 1) >>> 1 in 17 bits, truncated back to 16 bits.
  function automatic logic [15:0] scale_half(input logic [15:0] x);
    logic [16:0] sum;
    sum = {x[15], x} + 17'd1;
    return sum[16:1];
  endfunction

  // Scale both complex components before they enter the FIFO.
  always_comb begin
    wdata_s = {scale_half(din[31:16]), scale_half(din[15:0])};
  end
`else
  // Words are stored exactly as received.
  always_comb begin
    wdata_s = din;
  end
`endif

  assign full_s = (level_q == LW'(DEPTH));

  // Burst tracking: word index, gap timeout, completed-frame counter.
  always_comb begin
    state_d    = state_q;
    widx_d     = widx_q;
    gap_d      = gap_q;
    frame_d    = frame_q;
    last_tag_s = 1'b0;
    timeout_s  = 1'b0;
    if (rst) begin
      state_d = ST_IDLE;
      widx_d  = WW'(1'b0);
      gap_d   = GW'(1'b0);
      frame_d = 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (din_v) begin
            gap_d = GW'(1'b0);
            if (WLAST == WW'(1'b0)) begin
              // Single-word bursts: every word is a complete burst.
              last_tag_s = 1'b1;
              frame_d    = frame_q + 8'd1;
              widx_d     = WW'(1'b0);
            end else begin
              state_d = ST_COLLECT;
              widx_d  = WW'(1'b1);
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_COLLECT: begin
          if (din_v) begin
            gap_d = GW'(1'b0);
            if (widx_q == WLAST) begin
              last_tag_s = 1'b1;
              frame_d    = frame_q + 8'd1;
              state_d    = ST_IDLE;
              widx_d     = WW'(1'b0);
            end else begin
              widx_d = widx_q + WW'(1'b1);
            end
          end else if (gap_q == GLAST) begin
            // Burst abandoned; stored words keep their (untagged) state.
            timeout_s = 1'b1;
            state_d   = ST_IDLE;
            widx_d    = WW'(1'b0);
            gap_d     = GW'(1'b0);
          end else begin
            gap_d = gap_q + GW'(1'b1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          widx_d  = WW'(1'b0);
          gap_d   = GW'(1'b0);
        end
      endcase
    end
  end

  // FIFO pointers, occupancy and the registered head-of-queue word.
  always_comb begin
    wr_en_s      = 1'b0;
    rd_en_s      = 1'b0;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    level_d      = level_q;
    dout_valid_d = dout_valid_q;
    dout_d       = dout_q;
    dout_last_d  = dout_last_q;
    if (rst) begin
      wptr_d       = AW'(1'b0);
      rptr_d       = AW'(1'b0);
      level_d      = LW'(1'b0);
      dout_valid_d = 1'b0;
      dout_d       = 32'd0;
      dout_last_d  = 1'b0;
    end else begin
      // Full check uses pre-edge occupancy: no pass-through when full.
      wr_en_s = din_v && !full_s;
      rd_en_s = dout_valid_q && dout_ready;
      if (wr_en_s) begin
        wptr_d = wptr_q + AW'(1'b1);
      end else begin
        wptr_d = wptr_q;
      end
      if (rd_en_s) begin
        rptr_d = rptr_q + AW'(1'b1);
      end else begin
        rptr_d = rptr_q;
      end
      level_d      = level_q + LW'(wr_en_s) - LW'(rd_en_s);
      dout_valid_d = (level_d != LW'(1'b0));
      if (level_d != LW'(1'b0)) begin
        // New head is either the word being written now or a stored one.
        if (wr_en_s && (rptr_d == wptr_q)) begin
          dout_d      = wdata_s;
          dout_last_d = last_tag_s;
        end else begin
          dout_d      = mem_q[rptr_d][31:0];
          dout_last_d = mem_q[rptr_d][32];
        end
      end else begin
        dout_d      = dout_q;
        dout_last_d = dout_last_q;
      end
    end
  end

  // Sticky error flags: a set event wins over a same-cycle clear.
  always_comb begin
    ovf_set_s   = !rst && din_v && full_s;
    overflow_d  = overflow_q;
    burst_err_d = burst_err_q;
    if (rst) begin
      overflow_d  = 1'b0;
      burst_err_d = 1'b0;
    end else begin
      if (ovf_set_s) begin
        overflow_d = 1'b1;
      end else if (clr_err) begin
        overflow_d = 1'b0;
      end else begin
        overflow_d = overflow_q;
      end
      if (timeout_s) begin
        burst_err_d = 1'b1;
      end else if (clr_err) begin
        burst_err_d = 1'b0;
      end else begin
        burst_err_d = burst_err_q;
      end
    end
  end

  // Word storage: written only on accepted words, never reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wptr_q] <= {last_tag_s, wdata_s};
    end
  end

  // State registers; reset values are computed in the *_d logic.
  always_ff @(posedge clk) begin
    wptr_q       <= wptr_d;
    rptr_q       <= rptr_d;
    level_q      <= level_d;
    dout_valid_q <= dout_valid_d;
    dout_q       <= dout_d;
    dout_last_q  <= dout_last_d;
    state_q      <= state_d;
    widx_q       <= widx_d;
    gap_q        <= gap_d;
    frame_q      <= frame_d;
    overflow_q   <= overflow_d;
    burst_err_q  <= burst_err_d;
  end

  assign dout_valid = dout_valid_q;
  assign dout       = dout_q;
  assign dout_last  = dout_last_q;
  assign level      = level_q;
  assign overflow   = overflow_q;
  assign burst_err  = burst_err_q;
  assign frame_cnt  = frame_q;

endmodule

// File: tb/tb_alpha_collector.sv
// Testbench for alpha_collector: a directed vector table for the nominal
// burst, hand-written multi-cycle sequences, and randomized traffic checked
// against a queue-based reference model.
module tb_alpha_collector;

  localparam int DEPTH = 16;
  localparam int BL    = 8;
  localparam int GM    = 4;

  logic        clk;
  logic        rst;
  logic        din_v;
  logic [31:0] din;
  logic        dout_ready;
  logic        clr_err;
  logic        dout_valid;
  logic [31:0] dout;
  logic        dout_last;
  logic [4:0]  level;
  logic        overflow;
  logic        burst_err;
  logic [7:0]  frame_cnt;

  int checks;
  int failures;

  // Reference model state
  logic [32:0] mq[$];
  bit          m_in;
  int          m_pos;
  int          m_idle;
  int          m_frames;
  bit          m_ovf;
  bit          m_berr;

  typedef struct {
    bit          v;
    logic [31:0] d;
    bit          rdy;
    bit          exp_valid;
    logic [31:0] exp_dout;
    bit          exp_last;
    int          exp_level;
    int          exp_frame;
  } vec_t;

  vec_t tbl[9];

  alpha_collector #(.DEPTH(DEPTH), .BURST_LEN(BL), .GAP_MAX(GM)) dut (
    .clk        (clk),
    .rst        (rst),
    .din_v      (din_v),
    .din        (din),
    .dout_ready (dout_ready),
    .clr_err    (clr_err),
    .dout_valid (dout_valid),
    .dout       (dout),
    .dout_last  (dout_last),
    .level      (level),
    .overflow   (overflow),
    .burst_err  (burst_err),
    .frame_cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] half16(input logic [15:0] x);
    logic signed [15:0] s;
    int v;
    s = x;
    v = s;
    v = (v + 1) >>> 1;
    return v[15:0];
  endfunction

  function automatic logic [31:0] tb_scale32(input logic [31:0] x);
`ifdef ALPHA_COLLECTOR_SCALE_EN
    return {half16(x[31:16]), half16(x[15:0])};
`else
    return x;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one rising edge using the inputs now applied.
  task automatic model_edge();
    bit full;
    bit ovs;
    bit bes;
    bit last;
    int pos;
    if (rst) begin
      mq.delete();
      m_in = 0; m_pos = 0; m_idle = 0; m_frames = 0; m_ovf = 0; m_berr = 0;
      return;
    end
    full = (mq.size() == DEPTH);
    ovs  = 0;
    bes  = 0;
    if (mq.size() != 0 && dout_ready) void'(mq.pop_front());
    if (din_v) begin
      pos  = m_in ? m_pos : 0;
      last = (pos == BL - 1);
      if (!full) mq.push_back({last, tb_scale32(din)});
      else ovs = 1;
      if (last) begin
        m_frames = (m_frames + 1) % 256;
        m_in = 0;
        m_pos = 0;
      end else begin
        m_in = 1;
        m_pos = pos + 1;
      end
      m_idle = 0;
    end else if (m_in) begin
      m_idle++;
      if (m_idle == GM) begin
        m_in = 0; m_pos = 0; m_idle = 0; bes = 1;
      end
    end
    if (ovs) m_ovf = 1; else if (clr_err) m_ovf = 0;
    if (bes) m_berr = 1; else if (clr_err) m_berr = 0;
  endtask

  task automatic compare_model();
    check("valid", 32'(dout_valid), 32'(mq.size() != 0));
    check("level", 32'(level), 32'(mq.size()));
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("burst_err", 32'(burst_err), 32'(m_berr));
    check("frame_cnt", 32'(frame_cnt), 32'(m_frames));
    if (mq.size() != 0) begin
      check("dout", dout, mq[0][31:0]);
      check("dout_last", 32'(dout_last), 32'(mq[0][32]));
    end
  endtask

  task automatic cycle(input bit v, input logic [31:0] d, input bit r, input bit c);
    din_v      = v;
    din        = d;
    dout_ready = r;
    clr_err    = c;
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(1'b1, 32'h1234_5678, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    int dens_v;
    int dens_r;
    int f0;
    checks   = 0;
    failures = 0;
    rst = 1'b1; din_v = 1'b0; din = 32'h0; dout_ready = 1'b0; clr_err = 1'b0;
    mq.delete();
    m_in = 0; m_pos = 0; m_idle = 0; m_frames = 0; m_ovf = 0; m_berr = 0;

    // Nominal burst vectors: each word appears one cycle after input.
    for (int i = 0; i < 8; i++) begin
      tbl[i].v         = 1'b1;
      tbl[i].d         = {16'(i + 1), 16'(i + 1)};
      tbl[i].rdy       = 1'b1;
      tbl[i].exp_valid = 1'b1;
      tbl[i].exp_dout  = tb_scale32({16'(i + 1), 16'(i + 1)});
      tbl[i].exp_last  = (i == 7);
      tbl[i].exp_level = 1;
      tbl[i].exp_frame = (i == 7) ? 1 : 0;
    end
    tbl[8].v = 1'b0; tbl[8].d = 32'h0; tbl[8].rdy = 1'b1;
    tbl[8].exp_valid = 1'b0; tbl[8].exp_dout = 32'h0; tbl[8].exp_last = 1'b0;
    tbl[8].exp_level = 0; tbl[8].exp_frame = 1;

    // Reset state
    do_reset();
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_dout", dout, 32'd0);
    check("rst_last", 32'(dout_last), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_berr", 32'(burst_err), 32'd0);
    check("rst_frame", 32'(frame_cnt), 32'd0);

    // Nominal burst from the table
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].rdy, 1'b0);
      check("tbl_valid", 32'(dout_valid), 32'(tbl[i].exp_valid));
      check("tbl_level", 32'(level), 32'(tbl[i].exp_level));
      check("tbl_frame", 32'(frame_cnt), 32'(tbl[i].exp_frame));
      if (tbl[i].exp_valid) begin
        check("tbl_dout", dout, tbl[i].exp_dout);
        check("tbl_last", 32'(dout_last), 32'(tbl[i].exp_last));
      end
    end

    // Backpressure and overflow: 20 words into a 16-deep FIFO
    do_reset();
    for (int k = 0; k < 20; k++) cycle(1'b1, 32'hA000_0001 + 32'(k), 1'b0, 1'b0);
    check("ovf_level", 32'(level), 32'd16);
    check("ovf_flag", 32'(overflow), 32'd1);
    for (int j = 0; j < 16; j++) begin
      check("ovf_order", dout, tb_scale32(32'hA000_0001 + 32'(j)));
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
    end
    check("ovf_drained", 32'(dout_valid), 32'd0);
    check("ovf_still_set", 32'(overflow), 32'd1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Gap timeout after 3 words, then a complete burst
    do_reset();
    f0 = m_frames;
    for (int k = 0; k < 3; k++) cycle(1'b1, 32'hC000_0000 + 32'(k), 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("gap_not_yet", 32'(burst_err), 32'd0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
    check("gap_berr", 32'(burst_err), 32'd1);
    check("gap_frame", 32'(frame_cnt), 32'(f0));
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, 32'hD000_0000 + 32'(k), 1'b1, 1'b0);
      check("gap_burst_last", 32'(dout_last), 32'(k == 7));
    end
    check("gap_burst_frame", 32'(frame_cnt), 32'(f0 + 1));
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    check("berr_cleared", 32'(burst_err), 32'd0);

    // Simultaneous read and write at level 5
    do_reset();
    for (int k = 0; k < 5; k++) cycle(1'b1, 32'hE000_0000 + 32'(k), 1'b0, 1'b0);
    check("rw_level0", 32'(level), 32'd5);
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 32'hE100_0000 + 32'(k), 1'b1, 1'b0);
      check("rw_level", 32'(level), 32'd5);
    end
    for (int k = 0; k < 6; k++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

    // Reset mid-burst with a non-empty FIFO
    for (int k = 0; k < 4; k++) cycle(1'b1, 32'hF000_0000 + 32'(k), 1'b0, 1'b0);
    rst = 1'b1;
    cycle(1'b1, 32'hF0F0_F0F0, 1'b1, 1'b0);
    rst = 1'b0;
    check("mrst_valid", 32'(dout_valid), 32'd0);
    check("mrst_dout", dout, 32'd0);
    check("mrst_level", 32'(level), 32'd0);
    check("mrst_frame", 32'(frame_cnt), 32'd0);
    for (int k = 0; k < 8; k++) cycle(1'b1, 32'h0101_0000 + 32'(k), 1'b1, 1'b0);
    check("mrst_burst_frame", 32'(frame_cnt), 32'd1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);

`ifdef ALPHA_COLLECTOR_SCALE_EN
    // Scaling corner values
    cycle(1'b1, 32'h7FFF_8000, 1'b1, 1'b0);
    check("scale_a", dout, 32'h4000_C000);
    cycle(1'b1, 32'hFFFF_0001, 1'b1, 1'b0);
    check("scale_b", dout, 32'h0000_0001);
    cycle(1'b0, 32'h0, 1'b1, 1'b0);
`endif

    // Randomized traffic against the reference model
    dens_v = 90;
    dens_r = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) begin
        dens_v = $urandom_range(10, 100);
        dens_r = $urandom_range(5, 100);
      end
      rst = ($urandom_range(0, 299) == 0);
      cycle($urandom_range(0, 99) < dens_v, $urandom, $urandom_range(0, 99) < dens_r,
            $urandom_range(0, 29) == 0);
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
